inverse_seq: RTL and testbench
==============================

Name: inverse_seq

Overview:
Gauss-Jordan sequencer for the matrix inverse datapath. The datapath holds the N×N augmented matrix [A|I] and performs individual row operations. This block issues those operations in order: pivot probe, row swap, normalize, eliminate. It also detects a singular matrix. It sits between the top-level start/status interface and the row-operation port of the inverse datapath.

Parameters:
N, 4, matrix dimension (2..16).
RW, $clog2(N), row/column index width (minimum 1).

Ports:
clk  in  1  system clock, all state on rising edge.
rst_n  in  1  asynchronous active-low reset.
start  in  1  pulse; begins inversion when idle, ignored when busy.
abort  in  1  level; cancels the run in progress.
busy  out  1  high from accepted start until done/singular/aborted pulse.
done  out  1  one-cycle pulse; inversion completed successfully.
singular  out  1  one-cycle pulse; no nonzero pivot found.
aborted  out  1  one-cycle pulse; run cancelled by abort.
op_valid  out  1  row-operation request.
op_ready  in  1  datapath accepts request when op_valid & op_ready at clk edge.
op_code  out  2  0 PROBE, 1 SWAP, 2 NORM, 3 ELIM.
op_row_a  out  RW  PROBE/NORM: target row; SWAP: first row; ELIM: pivot row k.
op_row_b  out  RW  SWAP: second row; ELIM: row being eliminated; else 0.
op_col  out  RW  current pivot column k.
op_ack  in  1  one-cycle completion pulse for the outstanding op.
ack_zero  in  1  valid with op_ack on PROBE: element[row_a][col] == 0.

Behaviour:
- Reset: busy, done, singular, aborted, op_valid = 0; op_code, op_row_a, op_row_b, op_col = 0; state IDLE; k = 0.
- Handshake: at most one op outstanding. While op_valid is high, op_code, op_row_a, op_row_b and op_col stay stable until accepted. op_valid drops the cycle after acceptance. op_ack arrives ≥1 cycle after acceptance, and the next op_valid is asserted no earlier than the cycle after op_ack. op_ack outside an outstanding op is ignored.
- States: IDLE, PROBE, SWAP, NORM, ELIM, NEXT, FIN. Each op state has an issue phase and a wait-for-ack phase.
- IDLE: on start, busy=1, k=0, r=0. Go to PROBE with row_a=k.
- PROBE (row r, col k):
  - ack with ack_zero=0 and r==k → NORM.
  - ack with ack_zero=0 and r>k → SWAP(a=k, b=r).
  - ack with ack_zero=1 and r<N-1 → r+1, PROBE again.
  - ack with ack_zero=1 and r==N-1 → FIN with singular.
- SWAP: ack → NORM(row k).
- NORM: ack → ELIM with i = first row ≠ k.
- ELIM(a=k, b=i): row i is never equal to k. On ack, advance i to the next row ≠ k; after the last row → NEXT.
- NEXT: if k==N-1 → FIN with success; else k+1, r=k+1, PROBE.
- FIN: single cycle. Pulses exactly one of done/singular/aborted, clears busy in the same cycle, returns to IDLE. Outputs 1 cycle after the final op_ack.
- Op count for a nonsingular matrix with no swaps: N·(N+1). For N=4 that is 20.
- abort, sampled each cycle while busy:
  - op_valid pending and not accepted → drop op_valid next cycle, go to FIN(aborted).
  - op outstanding → wait for its op_ack, then FIN(aborted).
  - start and abort together while idle → start ignored.
- start while busy: ignored, no effect on sequence.
- rst_n asserted mid-run: immediate return to reset values. No pulse is emitted, and any ack arriving after reset release is ignored.
- Index counters never exceed N-1; no wrap-around.

Test Plan:
- N=4, start, identity-like datapath model (all probes nonzero, op_ready=1, ack 2 cycles after accept) → op sequence per k: PROBE(k,k), NORM(k), ELIM(k,i) for i≠k ascending. 20 ops total, single done pulse 1 cycle after the 20th ack, busy low the same cycle.
- N=4, model reports element[0][0]=0, [1][0]=0, [2][0]≠0 → PROBE r=0,1,2, then SWAP(a=0, b=2), NORM(0), ELIM(0,1..3); remaining columns normal, done pulse.
- N=3, column 1 probes zero at rows 1 and 2 → singular pulse 1 cycle after the ack of PROBE(row 2, col 1). No NORM issued for k=1. done never asserted.
- op_ready held low 5 cycles during NORM → op_valid, op_code=2, op_row_a and op_col stable all 5 cycles. Accepted on the 6th cycle; no duplicate issue.
- abort raised while an ELIM is outstanding, ack 3 cycles later → no new op_valid, aborted pulse 1 cycle after the ack. start pulsed while busy earlier has no effect.
- rst_n low for 1 cycle mid-PROBE, then start → outputs zero during reset, stale op_ack ignored, fresh run begins at PROBE(0,0).

Source files
------------

// File: rtl/inverse_seq.sv
// Gauss-Jordan sequencer: issues PROBE/SWAP/NORM/ELIM row operations to the
// inverse datapath in order, one outstanding op at a time, and flags singularity.
module inverse_seq #(
  parameter int N  = 4,
  parameter int RW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          singular,
  output logic          aborted,
  output logic          op_valid,
  input  logic          op_ready,
  output logic [1:0]    op_code,
  output logic [RW-1:0] op_row_a,
  output logic [RW-1:0] op_row_b,
  output logic [RW-1:0] op_col,
  input  logic          op_ack,
  input  logic          ack_zero
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_PROBE = 3'd1;
  localparam logic [2:0] S_SWAP  = 3'd2;
  localparam logic [2:0] S_NORM  = 3'd3;
  localparam logic [2:0] S_ELIM  = 3'd4;
  localparam logic [2:0] S_NEXT  = 3'd5;
  localparam logic [2:0] S_FIN   = 3'd6;

  localparam logic [1:0] OP_PROBE = 2'd0;
  localparam logic [1:0] OP_SWAP  = 2'd1;
  localparam logic [1:0] OP_NORM  = 2'd2;
  localparam logic [1:0] OP_ELIM  = 2'd3;

  localparam logic [RW-1:0] LAST = RW'(N - 1);

  // Handshake: an op is accepted on a clock edge with op_valid & op_ready;
  // op_valid then drops and the op stays outstanding (waiting=1) until op_ack.
  logic [2:0]    state;
  logic          waiting;
  logic          abort_pend;
  logic [RW-1:0] k;
  logic [RW-1:0] r;
  logic [RW-1:0] i;

  logic [RW:0]   inc1;
  logic [RW:0]   inc2;
  logic [RW:0]   nxt_wide;
  logic [RW-1:0] i_next;
  logic [RW-1:0] first_i;
  logic          elim_last;

  // Next elimination row skips the pivot row; computed one bit wider so the
  // end-of-rows test never relies on wrap-around.
  always_comb begin
    inc1      = {1'b0, i} + (RW+1)'(1);
    inc2      = {1'b0, i} + (RW+1)'(2);
    nxt_wide  = (inc1 == {1'b0, k}) ? inc2 : inc1;
    elim_last = (nxt_wide > {1'b0, LAST});
    i_next    = nxt_wide[RW-1:0];
    first_i   = (k == '0) ? RW'(1) : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      waiting    <= 1'b0;
      abort_pend <= 1'b0;
      k          <= '0;
      r          <= '0;
      i          <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      singular   <= 1'b0;
      aborted    <= 1'b0;
      op_valid   <= 1'b0;
      op_code    <= OP_PROBE;
      op_row_a   <= '0;
      op_row_b   <= '0;
      op_col     <= '0;
    end else begin
      done     <= 1'b0;
      singular <= 1'b0;
      aborted  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            busy       <= 1'b1;
            k          <= '0;
            r          <= '0;
            abort_pend <= 1'b0;
            waiting    <= 1'b0;
            state      <= S_PROBE;
            op_valid   <= 1'b1;
            op_code    <= OP_PROBE;
            op_row_a   <= '0;
            op_row_b   <= '0;
            op_col     <= '0;
          end
        end
        S_FIN: state <= S_IDLE;
        S_NEXT: begin
          if (abort) begin
            state   <= S_FIN;
            busy    <= 1'b0;
            aborted <= 1'b1;
          end else begin
            k        <= k + RW'(1);
            r        <= k + RW'(1);
            state    <= S_PROBE;
            op_valid <= 1'b1;
            op_code  <= OP_PROBE;
            op_row_a <= k + RW'(1);
            op_row_b <= '0;
            op_col   <= k + RW'(1);
          end
        end
        default: begin
          if (!waiting) begin
            if (op_valid && op_ready) begin
              op_valid   <= 1'b0;
              waiting    <= 1'b1;
              abort_pend <= abort;
            end else if (abort) begin
              op_valid <= 1'b0;
              state    <= S_FIN;
              busy     <= 1'b0;
              aborted  <= 1'b1;
            end
          end else if (op_ack) begin
            waiting <= 1'b0;
            if (abort || abort_pend) begin
              abort_pend <= 1'b0;
              state      <= S_FIN;
              busy       <= 1'b0;
              aborted    <= 1'b1;
            end else begin
              case (state)
                S_PROBE: begin
                  if (!ack_zero) begin
                    op_valid <= 1'b1;
                    op_row_a <= k;
                    op_col   <= k;
                    if (r == k) begin
                      state    <= S_NORM;
                      op_code  <= OP_NORM;
                      op_row_b <= '0;
                    end else begin
                      state    <= S_SWAP;
                      op_code  <= OP_SWAP;
                      op_row_b <= r;
                    end
                  end else if (r == LAST) begin
                    state    <= S_FIN;
                    busy     <= 1'b0;
                    singular <= 1'b1;
                  end else begin
                    r        <= r + RW'(1);
                    op_valid <= 1'b1;
                    op_code  <= OP_PROBE;
                    op_row_a <= r + RW'(1);
                    op_row_b <= '0;
                    op_col   <= k;
                  end
                end
                S_SWAP: begin
                  state    <= S_NORM;
                  op_valid <= 1'b1;
                  op_code  <= OP_NORM;
                  op_row_a <= k;
                  op_row_b <= '0;
                  op_col   <= k;
                end
                S_NORM: begin
                  i        <= first_i;
                  state    <= S_ELIM;
                  op_valid <= 1'b1;
                  op_code  <= OP_ELIM;
                  op_row_a <= k;
                  op_row_b <= first_i;
                  op_col   <= k;
                end
                S_ELIM: begin
                  if (elim_last) begin
                    if (k == LAST) begin
                      state <= S_FIN;
                      busy  <= 1'b0;
                      done  <= 1'b1;
                    end else begin
                      state <= S_NEXT;
                    end
                  end else begin
                    i        <= i_next;
                    op_valid <= 1'b1;
                    op_code  <= OP_ELIM;
                    op_row_a <= k;
                    op_row_b <= i_next;
                    op_col   <= k;
                  end
                end
                default: state <= S_IDLE;
              endcase
            end
          end else if (abort) begin
            abort_pend <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inverse_seq.sv
// Bench for inverse_seq: a datapath model answers each accepted op from a
// per-run table of {probe answer, expected op} records and logs what it saw.
module tb_inverse_seq;

  typedef struct packed {
    logic [1:0] code;
    logic [1:0] a;
    logic [1:0] b;
    logic [1:0] col;
  } op_t;

  typedef struct {
    logic zero;
    op_t  op;
  } step_t;

  logic       clk;
  logic       rst_n    [2];
  logic       start    [2];
  logic       abort    [2];
  logic       op_ready [2];
  logic       op_ack   [2];
  logic       ack_zero [2];
  logic       busy     [2];
  logic       done     [2];
  logic       singular [2];
  logic       aborted  [2];
  logic       op_valid [2];
  logic [1:0] op_code  [2];
  logic [1:0] op_row_a [2];
  logic [1:0] op_row_b [2];
  logic [1:0] op_col   [2];

  inverse_seq #(.N(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n[0]), .start(start[0]), .abort(abort[0]),
    .busy(busy[0]), .done(done[0]), .singular(singular[0]), .aborted(aborted[0]),
    .op_valid(op_valid[0]), .op_ready(op_ready[0]), .op_code(op_code[0]),
    .op_row_a(op_row_a[0]), .op_row_b(op_row_b[0]), .op_col(op_col[0]),
    .op_ack(op_ack[0]), .ack_zero(ack_zero[0])
  );

  inverse_seq #(.N(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n[1]), .start(start[1]), .abort(abort[1]),
    .busy(busy[1]), .done(done[1]), .singular(singular[1]), .aborted(aborted[1]),
    .op_valid(op_valid[1]), .op_ready(op_ready[1]), .op_code(op_code[1]),
    .op_row_a(op_row_a[1]), .op_row_b(op_row_b[1]), .op_col(op_col[1]),
    .op_ack(op_ack[1]), .ack_zero(ack_zero[1])
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required end of test");
    $fatal(1, "watchdog");
  end

  // ---------------- model state ----------------
  op_t   log0 [$];
  op_t   log1 [$];
  step_t tab0 [$];
  step_t tab1 [$];
  int    cnt [2], delay [2], ack_cyc [2], end_cyc [2];
  int    n_done [2], n_sing [2], n_abt [2], nv [2];
  int    stall [2], stall_seen [2], stall_bad [2];
  logic  pz [2], end_busy [2];
  op_t   held [2];
  int    n_chk = 0;
  int    n_fail = 0;

  function automatic int log_size(int j);
    return (j == 0) ? log0.size() : log1.size();
  endfunction

  function automatic op_t log_at(int j, int n);
    return (j == 0) ? log0[n] : log1[n];
  endfunction

  function automatic int tab_size(int j);
    return (j == 0) ? tab0.size() : tab1.size();
  endfunction

  function automatic step_t tab_at(int j, int n);
    return (j == 0) ? tab0[n] : tab1[n];
  endfunction

  function automatic int n_end(int j);
    return n_done[j] + n_sing[j] + n_abt[j];
  endfunction

  // Datapath model, evaluated mid-cycle: drives op_ready/op_ack/ack_zero for
  // the coming edge and records pulses and accepted ops.
  task automatic model_step(int j);
    op_t cur;
    int  idx;
    cur = '{op_code[j], op_row_a[j], op_row_b[j], op_col[j]};
    if (done[j])     begin n_done[j]++; end_cyc[j] = cyc; end_busy[j] = busy[j]; end
    if (singular[j]) begin n_sing[j]++; end_cyc[j] = cyc; end_busy[j] = busy[j]; end
    if (aborted[j])  begin n_abt[j]++;  end_cyc[j] = cyc; end_busy[j] = busy[j]; end
    if (op_valid[j] && op_code[j] == 2'd2) nv[j]++;
    op_ack[j]   = 1'b0;
    ack_zero[j] = 1'b0;
    if (cnt[j] > 0) begin
      cnt[j]--;
      if (cnt[j] == 0) begin
        op_ack[j]   = 1'b1;
        ack_zero[j] = pz[j];
        ack_cyc[j]  = cyc;
      end
    end
    op_ready[j] = 1'b1;
    if (op_valid[j] && op_code[j] == 2'd2 && stall[j] > 0) begin
      if (stall_seen[j] == 0) held[j] = cur;
      else if (cur !== held[j]) stall_bad[j]++;
      stall[j]--;
      stall_seen[j]++;
      op_ready[j] = 1'b0;
    end else if (op_valid[j] && rst_n[j]) begin
      idx = log_size(j);
      if (j == 0) log0.push_back(cur); else log1.push_back(cur);
      pz[j]  = (idx < tab_size(j)) ? tab_at(j, idx).zero : 1'b0;
      cnt[j] = delay[j];
    end
  endtask

  always @(negedge clk) model_step(0);
  always @(negedge clk) model_step(1);

  // ---------------- driver / checker tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic clear(int j, int d);
    if (j == 0) begin log0.delete(); tab0.delete(); end
    else begin log1.delete(); tab1.delete(); end
    delay[j] = d; n_done[j] = 0; n_sing[j] = 0; n_abt[j] = 0; nv[j] = 0;
    stall[j] = 0; stall_seen[j] = 0; stall_bad[j] = 0;
  endtask

  task automatic add_op(int j, logic z, logic [1:0] c, logic [1:0] a,
                        logic [1:0] b, logic [1:0] col);
    step_t s;
    s.zero = z;
    s.op   = '{c, a, b, col};
    if (j == 0) tab0.push_back(s); else tab1.push_back(s);
  endtask

  // N=4, every pivot nonzero: PROBE(k), NORM(k), ELIM(k,i) for i != k ascending.
  task automatic fill_identity4();
    add_op(0,0,0,0,0,0); add_op(0,0,2,0,0,0); add_op(0,0,3,0,1,0); add_op(0,0,3,0,2,0); add_op(0,0,3,0,3,0);
    add_op(0,0,0,1,0,1); add_op(0,0,2,1,0,1); add_op(0,0,3,1,0,1); add_op(0,0,3,1,2,1); add_op(0,0,3,1,3,1);
    add_op(0,0,0,2,0,2); add_op(0,0,2,2,0,2); add_op(0,0,3,2,0,2); add_op(0,0,3,2,1,2); add_op(0,0,3,2,3,2);
    add_op(0,0,0,3,0,3); add_op(0,0,2,3,0,3); add_op(0,0,3,3,0,3); add_op(0,0,3,3,1,3); add_op(0,0,3,3,2,3);
  endtask

  task automatic pulse_start(int j);
    start[j] = 1'b1;
    tick();
    start[j] = 1'b0;
  endtask

  task automatic wait_end(int j, string name);
    for (int c = 0; c < 600; c++) begin
      if (n_end(j) > 0) break;
      tick();
    end
    check({name, "_finished"}, (n_end(j) > 0) ? 32'd1 : 32'd0, 32'd1);
    repeat (3) tick();
  endtask

  task automatic check_log(int j, string name, int upto);
    check({name, "_op_count"}, log_size(j), upto);
    for (int n = 0; n < upto && n < log_size(j); n++)
      check($sformatf("%s_op%0d", name, n), log_at(j, n), tab_at(j, n).op);
  endtask

  task automatic check_idle(int j, string name);
    check({name, "_outs"},
          {busy[j], done[j], singular[j], aborted[j], op_valid[j],
           op_code[j], op_row_a[j], op_row_b[j], op_col[j]}, 32'd0);
  endtask

  task automatic wait_op(int j, logic [1:0] code, string name);
    int seen;
    seen = 0;
    for (int c = 0; c < 200; c++) begin
      if (op_valid[j] && op_code[j] == code) begin seen = 1; break; end
      tick();
    end
    check({name, "_op_seen"}, seen, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    for (int j = 0; j < 2; j++) begin
      rst_n[j] = 1'b0; start[j] = 1'b0; abort[j] = 1'b0;
      op_ready[j] = 1'b1; op_ack[j] = 1'b0; ack_zero[j] = 1'b0;
      cnt[j] = 0; pz[j] = 1'b0; ack_cyc[j] = 0; end_cyc[j] = 0; end_busy[j] = 1'b0;
      held[j] = '0;
      clear(j, 2);
    end
    repeat (2) tick();
    check_idle(0, "reset4");
    check_idle(1, "reset3");
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    tick();

    // Plain run, all probes nonzero.
    clear(0, 2);
    fill_identity4();
    pulse_start(0);
    wait_end(0, "ident");
    check_log(0, "ident", 20);
    check("ident_done_cnt", n_done[0], 1);
    check("ident_other_pulses", n_sing[0] + n_abt[0], 0);
    check("ident_done_lat", end_cyc[0], ack_cyc[0] + 1);
    check("ident_busy_at_done", end_busy[0], 0);

    // Column 0 pivot found at row 2: SWAP(0,2) then normal flow.
    clear(0, 1);
    add_op(0,1,0,0,0,0); add_op(0,1,0,1,0,0); add_op(0,0,0,2,0,0); add_op(0,0,1,0,2,0);
    add_op(0,0,2,0,0,0); add_op(0,0,3,0,1,0); add_op(0,0,3,0,2,0); add_op(0,0,3,0,3,0);
    add_op(0,0,0,1,0,1); add_op(0,0,2,1,0,1); add_op(0,0,3,1,0,1); add_op(0,0,3,1,2,1); add_op(0,0,3,1,3,1);
    add_op(0,0,0,2,0,2); add_op(0,0,2,2,0,2); add_op(0,0,3,2,0,2); add_op(0,0,3,2,1,2); add_op(0,0,3,2,3,2);
    add_op(0,0,0,3,0,3); add_op(0,0,2,3,0,3); add_op(0,0,3,3,0,3); add_op(0,0,3,3,1,3); add_op(0,0,3,3,2,3);
    pulse_start(0);
    wait_end(0, "swap");
    check_log(0, "swap", 23);
    check("swap_done_cnt", n_done[0], 1);
    check("swap_done_lat", end_cyc[0], ack_cyc[0] + 1);

    // N=3, column 1 has no nonzero pivot.
    clear(1, 2);
    add_op(1,0,0,0,0,0); add_op(1,0,2,0,0,0); add_op(1,0,3,0,1,0); add_op(1,0,3,0,2,0);
    add_op(1,1,0,1,0,1); add_op(1,1,0,2,0,1);
    pulse_start(1);
    wait_end(1, "sing");
    check_log(1, "sing", 6);
    check("sing_pulse_cnt", n_sing[1], 1);
    check("sing_done_cnt", n_done[1], 0);
    check("sing_lat", end_cyc[1], ack_cyc[1] + 1);
    check("sing_busy_at_pulse", end_busy[1], 0);

    // First NORM stalled by op_ready low for 5 cycles.
    clear(0, 2);
    fill_identity4();
    stall[0] = 5;
    pulse_start(0);
    wait_end(0, "stall");
    check_log(0, "stall", 20);
    check("stall_cycles", stall_seen[0], 5);
    check("stall_unstable", stall_bad[0], 0);
    check("stall_norm_valid_cycles", nv[0], 9);
    check("stall_done_cnt", n_done[0], 1);

    // Abort while ELIM(0,1) outstanding, with a stray start while busy.
    clear(0, 3);
    fill_identity4();
    pulse_start(0);
    tick();
    pulse_start(0);
    wait_op(0, 2'd3, "abort");
    tick();
    abort[0] = 1'b1;
    wait_end(0, "abort");
    check_log(0, "abort", 3);
    check("abort_pulse_cnt", n_abt[0], 1);
    check("abort_done_cnt", n_done[0], 0);
    check("abort_lat", end_cyc[0], ack_cyc[0] + 1);
    check("abort_busy_at_pulse", end_busy[0], 0);
    pulse_start(0);
    repeat (3) tick();
    check("abort_start_ignored", {busy[0], op_valid[0]}, 0);
    check("abort_start_no_ops", log_size(0), 3);
    abort[0] = 1'b0;
    tick();

    // Reset mid-PROBE with the PROBE outstanding; its ack lands after release.
    clear(0, 3);
    fill_identity4();
    pulse_start(0);
    wait_op(0, 2'd0, "rst");
    tick();
    rst_n[0] = 1'b0;
    #1;
    check_idle(0, "rst_during");
    tick();
    rst_n[0] = 1'b1;
    repeat (5) tick();
    check_idle(0, "rst_after");
    check("rst_no_pulse", n_end(0), 0);
    check("rst_ops_before", log_size(0), 1);
    clear(0, 2);
    fill_identity4();
    pulse_start(0);
    wait_end(0, "rst_rerun");
    check_log(0, "rst_rerun", 20);
    check("rst_rerun_done_cnt", n_done[0], 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
